// File: rtl/ldl_rr_pri_burst_if.sv
// Request/grant bus for the aged-priority round-robin burst arbiter.
// The master drives requests and downstream ready; the slave (arbiter) drives the grant and beat strobes.
interface ldl_rr_pri_burst_if #(
  parameter int BIN_WIDTH = 3,
  parameter int COS_WIDTH = 2,
  parameter int LEN_WIDTH = 4,
  parameter int REQ_WIDTH = 1 << BIN_WIDTH
);
  logic [REQ_WIDTH-1:0]                req;
  logic [REQ_WIDTH-1:0][COS_WIDTH-1:0] cos;
  logic [REQ_WIDTH-1:0][LEN_WIDTH-1:0] len;
  logic                                ready;
  logic [REQ_WIDTH-1:0]                hot;
  logic [BIN_WIDTH-1:0]                bin;
  logic                                valid;
  logic                                last;

  modport master (output req, cos, len, ready, input hot, bin, valid, last);
  modport slave  (input req, cos, len, ready, output hot, bin, valid, last);
endinterface

// File: rtl/ldl_rr_pri_burst.sv
// Burst arbiter: picks a requester by {aged, cos} with round-robin tie-break,
// then streams len+1 beats to a ready-gated downstream.

// Per-requester age tracking and priority key.
module ldl_rr_pri_burst_lane #(
  parameter int COS_WIDTH = 2,
  parameter int AGE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [COS_WIDTH-1:0] cos,
  input  logic                 grant,
  input  logic                 win,
  output logic [COS_WIDTH:0]   key
);
  logic [7:0] age;
  logic       aged;

  assign aged = (age == 8'(AGE_LIMIT));
  assign key  = {aged, cos};

  // Losing requesters age toward the limit; winners and idle lanes restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) age <= '0;
    else if (grant) begin
      if (req && !win) age <= aged ? age : age + 8'd1;
      else             age <= '0;
    end
  end
endmodule

module ldl_rr_pri_burst #(
  parameter int BIN_WIDTH = 3,
  parameter int COS_WIDTH = 2,
  parameter int LEN_WIDTH = 4,
  parameter int AGE_LIMIT = 8,
  parameter int REQ_WIDTH = 1 << BIN_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  ldl_rr_pri_burst_if.slave bus
);
  typedef enum logic {IDLE, BURST} state_t;

  state_t                              state;
  logic [REQ_WIDTH-1:0]                hot_q;
  logic [BIN_WIDTH-1:0]                bin_q;
  logic [LEN_WIDTH-1:0]                cnt;
  logic [BIN_WIDTH-1:0]                rr_start;
  logic [REQ_WIDTH-1:0][COS_WIDTH:0]   key;
  logic [BIN_WIDTH-1:0]                win_idx;
  logic [REQ_WIDTH-1:0]                win_hot;
  logic                                grant;

  assign grant   = (state == IDLE) && (|bus.req);
  assign win_hot = REQ_WIDTH'(1) << win_idx;

  generate
    for (genvar g = 0; g < REQ_WIDTH; g++) begin : g_lane
      ldl_rr_pri_burst_lane #(
        .COS_WIDTH (COS_WIDTH),
        .AGE_LIMIT (AGE_LIMIT)
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .req   (bus.req[g]),
        .cos   (bus.cos[g]),
        .grant (grant),
        .win   (win_hot[g]),
        .key   (key[g])
      );
    end
  endgenerate

  // Scan from rr_start; strict '>' keeps the first-found lane among equal keys.
  always_comb begin
    logic [COS_WIDTH:0] best;
    logic               found;
    int                 idx;
    best    = '0;
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      idx = int'(rr_start) + i;
      if (idx >= REQ_WIDTH) idx = idx - REQ_WIDTH;
      if (bus.req[idx] && (!found || key[idx] > best)) begin
        found   = 1'b1;
        best    = key[idx];
        win_idx = BIN_WIDTH'(idx);
      end
    end
  end

  // rr_start holds the index after the last winner, so reset to 0 starts the search at lane 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      hot_q    <= '0;
      bin_q    <= '0;
      cnt      <= '0;
      rr_start <= '0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          state    <= BURST;
          hot_q    <= win_hot;
          bin_q    <= win_idx;
          cnt      <= bus.len[win_idx];
          rr_start <= (win_idx == BIN_WIDTH'(REQ_WIDTH - 1)) ? '0 : win_idx + BIN_WIDTH'(1);
        end
        BURST: if (bus.ready) begin
          if (cnt == '0) begin
            state <= IDLE;
            hot_q <= '0;
            bin_q <= '0;
          end else begin
            cnt <= cnt - LEN_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.valid = (state == BURST);
  assign bus.last  = (state == BURST) && (cnt == '0);
  assign bus.hot   = hot_q;
  assign bus.bin   = bin_q;
endmodule

// File: tb/tb_ldl_rr_pri_burst.sv
// Scoreboard bench: a grant-level reference model queues expected per-cycle outputs,
// a negedge monitor pops and compares; directed scenarios also check grant order and burst lengths.
module tb_ldl_rr_pri_burst;
  localparam int N  = 8;
  localparam int AL = 2;

  logic clk;
  logic rst;

  ldl_rr_pri_burst_if #(.BIN_WIDTH(3), .COS_WIDTH(2), .LEN_WIDTH(4), .REQ_WIDTH(N)) bus();

  ldl_rr_pri_burst #(
    .BIN_WIDTH (3),
    .COS_WIDTH (2),
    .LEN_WIDTH (4),
    .AGE_LIMIT (AL),
    .REQ_WIDTH (N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic         valid;
    logic [N-1:0] hot;
    logic [2:0]   bin;
    logic         last;
  } obs_t;

  obs_t expq[$];
  int   glog[$];
  int   blen[$];
  int   vectors = 0;
  int   errors  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: one expected observation per rising edge.
  initial begin
    int   age_m[N];
    int   start_m, cur, left, w, best_s, best_d, s, d;
    bit   busy;
    obs_t e;
    busy = 0; cur = 0; left = 0; start_m = 0;
    foreach (age_m[i]) age_m[i] = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        busy = 0; cur = 0; left = 0; start_m = 0;
        foreach (age_m[i]) age_m[i] = 0;
        expq.delete();
        expq.push_back('0);
      end else begin
        if (busy) begin
          if (bus.ready) begin
            if (left == 0) busy = 0;
            else left = left - 1;
          end
        end else if (bus.req != '0) begin
          w = -1; best_s = -1; best_d = N;
          for (int i = 0; i < N; i++) begin
            if (bus.req[i]) begin
              s = ((age_m[i] == AL) ? 4 : 0) + int'(bus.cos[i]);
              d = (i - start_m + N) % N;
              if (s > best_s || (s == best_s && d < best_d)) begin
                w = i; best_s = s; best_d = d;
              end
            end
          end
          for (int i = 0; i < N; i++) begin
            if (bus.req[i] && i != w) age_m[i] = (age_m[i] + 1 > AL) ? AL : age_m[i] + 1;
            else age_m[i] = 0;
          end
          start_m = (w + 1) % N;
          busy = 1; cur = w; left = int'(bus.len[w]);
        end
        e = '0;
        if (busy) begin
          e.valid = 1'b1;
          e.hot   = N'(1) << cur;
          e.bin   = 3'(cur);
          e.last  = (left == 0);
        end
        expq.push_back(e);
      end
    end
  end

  // Monitor: compare at the falling edge, log grant starts and burst lengths.
  initial begin
    obs_t a, e;
    bit   pv;
    int   run;
    pv = 0; run = 0;
    forever begin
      @(negedge clk);
      a.valid = bus.valid; a.hot = bus.hot; a.bin = bus.bin; a.last = bus.last;
      vectors++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t got v=%b hot=%h bin=%0d last=%b",
                 $time, a.valid, a.hot, a.bin, a.last);
      end else begin
        e = expq.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL obs t=%0t got v=%b hot=%h bin=%0d last=%b want v=%b hot=%h bin=%0d last=%b",
                   $time, a.valid, a.hot, a.bin, a.last, e.valid, e.hot, e.bin, e.last);
        end
      end
      if (a.valid && !pv) glog.push_back(int'(a.bin));
      if (a.valid) run++;
      if (!a.valid && pv) begin blen.push_back(run); run = 0; end
      pv = a.valid;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic idle_in();
    bus.req = '0; bus.cos = '0; bus.len = '0; bus.ready = 1'b1;
  endtask

  // Reset asserted just after a rising edge, released on a falling edge.
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_glog(input string name, input int want[$]);
    chk({name, "_count"}, glog.size(), want.size());
    for (int i = 0; i < want.size() && i < glog.size(); i++)
      chk($sformatf("%s_grant%0d", name, i), glog[i], want[i]);
  endtask

  initial begin
    int pat[5];
    int want[$];
    rst = 1'b0;
    idle_in();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Equal class: lanes 0 and 2 alternate with a bubble between grants.
    glog.delete(); blen.delete();
    bus.req = 8'h05;
    repeat (6) @(negedge clk);
    bus.req = '0;
    repeat (3) @(negedge clk);
    want = '{0, 2, 0};
    chk_glog("rr_equal", want);

    // Higher class wins first, runs 4 beats, then the lower class.
    do_reset();
    idle_in(); glog.delete(); blen.delete();
    bus.cos[7] = 2'd2; bus.cos[0] = 2'd1; bus.len[7] = 4'd3;
    bus.req = 8'h81;
    @(negedge clk);
    bus.req = 8'h01;
    repeat (5) @(negedge clk);
    bus.req = '0;
    repeat (3) @(negedge clk);
    want = '{7, 0};
    chk_glog("cos_pri", want);
    chk("cos_pri_len7", (blen.size() > 0) ? blen[0] : -1, 4);

    // Backpressure stretches a 3-beat burst to 5 valid cycles.
    do_reset();
    idle_in(); glog.delete(); blen.delete();
    bus.len[0] = 4'd2; bus.req = 8'h01;
    pat = '{1, 0, 0, 1, 1};
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      bus.ready = pat[k][0];
      bus.req = '0;
      @(negedge clk);
    end
    bus.ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_bursts", blen.size(), 1);
    chk("stall_len", (blen.size() > 0) ? blen[0] : -1, 5);

    // Aging lets a low class through after AL losses.
    do_reset();
    idle_in(); glog.delete(); blen.delete();
    bus.cos[1] = 2'd3; bus.cos[4] = 2'd0; bus.req = 8'h12;
    repeat (12) @(negedge clk);
    bus.req = '0;
    repeat (3) @(negedge clk);
    want = '{1, 1, 4, 1, 1, 4};
    chk_glog("aging", want);

    // Async reset mid-burst clears outputs at once and restarts the search at 0.
    do_reset();
    idle_in(); glog.delete();
    bus.len[0] = 4'd3; bus.req = 8'h01;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_hot", int'(bus.hot), 0);
    chk("rst_bin", int'(bus.bin), 0);
    bus.len = '0; bus.req = 8'h24;
    @(negedge clk);
    glog.delete();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus.req = '0;
    repeat (3) @(negedge clk);
    want = '{2};
    chk_glog("rst_restart", want);

    // Dropped request still finishes its two beats and is not re-granted.
    do_reset();
    idle_in(); glog.delete(); blen.delete();
    bus.len[3] = 4'd1; bus.req = 8'h08;
    @(negedge clk);
    bus.req = '0;
    repeat (6) @(negedge clk);
    chk("drop_grants", glog.size(), 1);
    chk("drop_len", (blen.size() > 0) ? blen[0] : -1, 2);

    // Randomised traffic with occasional async resets.
    do_reset();
    idle_in();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 8'($urandom & $urandom);
      for (int i = 0; i < N; i++) begin
        bus.cos[i] = 2'($urandom_range(0, 3));
        bus.len[i] = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      end
      bus.ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else @(negedge clk);
    end
    idle_in();
    repeat (30) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
